// File: rtl/trivia_question_fetch.sv
// Fetches one fixed-size question record from word memory and streams it as bytes.
// Define TRIVIA_FETCH_PREFETCH_EN to overlap the next word read with unpacking (gapless output).
module trivia_question_fetch #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned REC_WORDS = 16,
    parameter int unsigned MEM_DEPTH = 25000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  question_idx,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [14:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_last
);
    localparam logic [23:0] BASE24  = 24'(BASE_ADDR);
    localparam logic [23:0] REC24   = 24'(REC_WORDS);
    localparam logic [23:0] DEPTH24 = 24'(MEM_DEPTH);
    localparam logic [23:0] LAST24  = 24'(REC_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, UNPACK, DONE} state_t;
    state_t state, next_state;

    logic [23:0] rec_base;
    logic [23:0] word;
    logic [23:0] base_calc;
    logic [1:0]  byte_idx;
    logic [31:0] word_reg;
    logic [7:0]  cur_byte;
    logic        err_flag;
    logic        out_of_range;
    logic        last_word;
    logic        byte_last;
`ifdef TRIVIA_FETCH_PREFETCH_EN
    logic [31:0] pf_reg;
    logic        pf_issued;
    logic        pf_pending;
    logic        pf_req;
`endif

    assign base_calc    = BASE24 + 24'(question_idx) * REC24;
    assign out_of_range = (base_calc + REC24) > DEPTH24;
    assign last_word    = (word == LAST24);

    always_comb begin
        cur_byte = word_reg[7:0];
        case (byte_idx)
            2'd0: cur_byte = word_reg[7:0];
            2'd1: cur_byte = word_reg[15:8];
            2'd2: cur_byte = word_reg[23:16];
            2'd3: cur_byte = word_reg[31:24];
        endcase
    end

    assign byte_last = (cur_byte == 8'h00) || ((byte_idx == 2'd3) && last_word);

`ifdef TRIVIA_FETCH_PREFETCH_EN
    // One read of the following word per word held in word_reg; never past the record end.
    assign pf_req = (state == UNPACK) && !pf_issued && !last_word;
`endif

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state     = state;
        busy           = 1'b1;
        done           = 1'b0;
        err            = 1'b0;
        char_valid     = 1'b0;
        char_data      = '0;
        char_last      = 1'b0;
        mem_chipselect = 1'b0;
        mem_address    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = out_of_range ? DONE : ADDR;
            end
            ADDR: begin
                mem_chipselect = 1'b1;
                mem_address    = 15'(rec_base + word);
                next_state     = WAIT;
            end
            WAIT: next_state = UNPACK;
            UNPACK: begin
                char_valid = 1'b1;
                char_data  = cur_byte;
                char_last  = byte_last;
`ifdef TRIVIA_FETCH_PREFETCH_EN
                if (pf_req) begin
                    mem_chipselect = 1'b1;
                    mem_address    = 15'(rec_base + word + 24'd1);
                end
`endif
                if (char_ready) begin
                    if (byte_last) next_state = DONE;
`ifndef TRIVIA_FETCH_PREFETCH_EN
                    else if (byte_idx == 2'd3) next_state = ADDR;
`endif
                end
            end
            DONE: begin
                done       = 1'b1;
                err        = err_flag;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rec_base   <= '0;
            word       <= '0;
            byte_idx   <= '0;
            word_reg   <= '0;
            err_flag   <= 1'b0;
`ifdef TRIVIA_FETCH_PREFETCH_EN
            pf_reg     <= '0;
            pf_issued  <= 1'b0;
            pf_pending <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef TRIVIA_FETCH_PREFETCH_EN
                    pf_issued  <= 1'b0;
                    pf_pending <= 1'b0;
`endif
                    if (start) begin
                        rec_base <= base_calc;
                        word     <= '0;
                        byte_idx <= '0;
                        err_flag <= out_of_range;
                    end
                end
                WAIT: begin
                    word_reg <= mem_readdata;
                    byte_idx <= '0;
                end
                UNPACK: begin
`ifdef TRIVIA_FETCH_PREFETCH_EN
                    pf_pending <= pf_req;
                    if (pf_req) pf_issued <= 1'b1;
                    if (pf_pending) pf_reg <= mem_readdata;
`endif
                    if (char_ready && !byte_last) begin
                        if (byte_idx == 2'd3) begin
                            word     <= word + 24'd1;
                            byte_idx <= '0;
`ifdef TRIVIA_FETCH_PREFETCH_EN
                            // Prefetch data has always landed by the time byte 3 is reached.
                            word_reg  <= pf_reg;
                            pf_issued <= 1'b0;
`endif
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/trivia_question_fetch.md
TRIVIA_QUESTION_FETCH -- requirements
Module: trivia_question_fetch

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: word address of question record 0 in on-chip memory.
REQ-002 SHALL have parameter REC_WORDS, default 16: 32-bit words per question record (64 chars).
REQ-003 SHALL have parameter MEM_DEPTH, default 25000: valid word count of the memory.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to fetch a record.
REQ-007 SHALL have port question_idx  in  8  record index, sampled with start.
REQ-008 SHALL have port busy  out  1  high from accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse at fetch end.
REQ-010 SHALL have port err  out  1  valid with done: record out of range.
REQ-011 SHALL have port mem_address  out  15  memory word address.
REQ-012 SHALL have port mem_chipselect  out  1  read strobe, one cycle per word.
REQ-013 SHALL have port mem_write  out  1  tied 0.
REQ-014 SHALL have port mem_byteenable  out  4  tied 4'hF.
REQ-015 SHALL have port mem_readdata  in  32  data valid one cycle after address strobe.
REQ-016 SHALL have port char_data  out  8  character byte.
REQ-017 SHALL have port char_valid  out  1  char_data valid.
REQ-018 SHALL have port char_ready  in  1  consumer accepts when valid and ready.
REQ-019 SHALL have port char_last  out  1  marks final character of record.

Function
REQ-020 States SHALL be IDLE, ADDR, WAIT, UNPACK, DONE.
REQ-021 IDLE: start=1 SHALL latch question_idx and compute rec_base = BASE_ADDR + question_idx*REC_WORDS in 24-bit arithmetic.
REQ-022 If rec_base+REC_WORDS > MEM_DEPTH, SHALL go to DONE with err=1 and issue no memory access.
REQ-023 Otherwise SHALL go to ADDR; ADDR drives mem_address=rec_base+word, mem_chipselect=1 for exactly one cycle, then WAIT.
REQ-024 WAIT SHALL capture mem_readdata into a word register, then UNPACK.
REQ-025 UNPACK SHALL present bytes little-endian: [7:0] first, [31:24] last, one byte per accepted handshake.
REQ-026 char_data/char_valid/char_last SHALL stay stable while char_valid=1 and char_ready=0.
REQ-027 A byte equal to 8'h00 SHALL be emitted with char_last=1 and end the record (remaining bytes and words discarded).
REQ-028 Without NUL, byte 3 of word REC_WORDS-1 SHALL carry char_last=1.
REQ-029 After the last accepted byte of a non-final word, SHALL return to ADDR with word+1.
REQ-030 After char_last is accepted, SHALL enter DONE: done=1, err=0 for one cycle, then IDLE.
REQ-031 Latency: start at edge k -> mem_chipselect high cycle k+1 -> first char_valid cycle k+3.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 busy SHALL be 1 in ADDR, WAIT, UNPACK, DONE and 0 in IDLE.

Reset
REQ-034 reset_n=0 at an edge SHALL force IDLE regardless of state, aborting any fetch with no done pulse.
REQ-035 Reset values SHALL be: busy=0, done=0, err=0, char_valid=0, char_last=0, char_data=0, mem_chipselect=0, mem_address=0.

Configuration
REQ-036 With TRIVIA_FETCH_PREFETCH_EN defined, SHALL issue the next word's read during UNPACK of the current word into a one-word prefetch register, so with char_ready held 1 char_valid is continuous (1 char/cycle) across word boundaries.
REQ-037 Prefetch SHALL never read beyond word REC_WORDS-1; a prefetched word is discarded on NUL or reset.
REQ-038 Without TRIVIA_FETCH_PREFETCH_EN, SHALL follow REQ-029, with a 2-cycle char_valid gap per word boundary.

Verification
REQ-039 idx=0, mem[0]=32'h44434241, mem[1]=32'h00000045, ready=1 -> chars 41,42,43,44,45,00; last on 00; done, err=0.
REQ-040 idx=2, REC_WORDS=16, no NUL -> reads addresses 32..47 exactly once each; 64 chars; last on 64th; no-prefetch gap 2 cycles per boundary, prefetch gap 0.
REQ-041 ready toggled 1-0-1 each cycle -> char_data held during stalls; byte sequence identical to REQ-039.
REQ-042 idx=255 with MEM_DEPTH=25000, BASE_ADDR=21000 -> done with err=1 one cycle after start; mem_chipselect never asserted.
REQ-043 reset_n=0 during UNPACK of word 1 -> next cycle all outputs at REQ-035 values; new start fetches from word 0.
REQ-044 start pulsed again while busy -> ignored; only one done pulse.
